// File: rtl/srl_fifo.sv
// srl_fifo: SRL-style elastic FIFO. A WIDTH x DEPTH shift array whose read tap
// follows the fill level, with valid/ready handshakes and registered occupancy flags.
module srl_fifo #(
  parameter int               WIDTH           = 8,
  parameter int               DEPTH           = 32,
  parameter int               AFULL_THR       = DEPTH - 2,
  parameter int               AEMPTY_THR      = 1,
  parameter logic [WIDTH-1:0] INIT            = '0,
  parameter bit               IS_CLK_INVERTED = 1'b0
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         CE,
  input  logic                         CLR,
  input  logic [WIDTH-1:0]             S_DATA,
  input  logic                         S_VALID,
  output logic                         S_READY,
  output logic [WIDTH-1:0]             M_DATA,
  output logic                         M_VALID,
  input  logic                         M_READY,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT,
  output logic                         AFULL,
  output logic                         AEMPTY
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic             clk_act;
  logic [WIDTH-1:0] mem [DEPTH] = '{default: INIT};
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt;
  logic             rdy_r;
  logic             empty_r;
  logic             full_r;
  logic             afull_r;
  logic             aempty_r;
  logic             push;
  logic             pop;
  logic [AW-1:0]    tap;

  assign clk_act = CLK ^ IS_CLK_INVERTED;

  // Ready/valid come only from registered state, so a pop at full never
  // opens a same-cycle push.
  assign S_READY = CE & rdy_r & ~full_r;
  assign M_VALID = CE & ~empty_r;
  assign push    = S_VALID & S_READY;
  assign pop     = M_READY & M_VALID;

  always_comb begin
    count_nxt = count_r;
    if (CLR)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count_r + CW'(1);
    else if (pop && !push)
      count_nxt = count_r - CW'(1);
  end

  // Oldest word sits at COUNT-1; with nothing stored the tap rests on entry 0.
  assign tap    = (count_r == '0) ? '0 : AW'(count_r - CW'(1));
  assign M_DATA = mem[tap];
  assign COUNT  = count_r;
  assign AFULL  = afull_r;
  assign AEMPTY = aempty_r;

  always_ff @(posedge clk_act) begin
    if (push && !CLR) begin
      mem[0] <= S_DATA;
      for (int i = 1; i < DEPTH; i++)
        mem[i] <= mem[i-1];
    end
  end

  always_ff @(posedge clk_act or negedge RST_N) begin
    if (!RST_N) begin
      count_r  <= '0;
      rdy_r    <= 1'b0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
    end else if (CE) begin
      rdy_r    <= 1'b1;
      count_r  <= count_nxt;
      empty_r  <= (count_nxt == '0);
      full_r   <= (count_nxt == CW'(DEPTH));
      afull_r  <= (int'(count_nxt) >= AFULL_THR);
      aempty_r <= (int'(count_nxt) <= AEMPTY_THR);
    end
  end

endmodule

// File: tb/tb_srl_fifo.sv
// Bench for srl_fifo: a 8x32 rising-edge instance and a 8x3 falling-edge
// instance, each checked every cycle against a queue-based model.
module tb_srl_fifo;

  localparam int W    = 8;
  localparam int DA   = 32;
  localparam int DB   = 3;
  localparam int CWA  = $clog2(DA + 1);
  localparam int CWB  = $clog2(DB + 1);
  localparam int AF_A = DA - 2;
  localparam int AE_A = 1;
  localparam int AF_B = DB - 2;
  localparam int AE_B = 1;

  logic clk = 1'b0;
  logic rst_n;

  logic           a_ce, a_clr, a_s_valid, a_m_ready;
  logic [W-1:0]   a_s_data, a_m_data;
  logic           a_s_ready, a_m_valid, a_afull, a_aempty;
  logic [CWA-1:0] a_count;

  logic           b_ce, b_clr, b_s_valid, b_m_ready;
  logic [W-1:0]   b_s_data, b_m_data;
  logic           b_s_ready, b_m_valid, b_afull, b_aempty;
  logic [CWB-1:0] b_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] q_a[$];
  logic [W-1:0] q_b[$];
  bit rdy_a, rdy_b;

  always #5 clk = ~clk;

  srl_fifo #(.WIDTH(W), .DEPTH(DA)) u_dut_a (
    .CLK(clk), .RST_N(rst_n), .CE(a_ce), .CLR(a_clr),
    .S_DATA(a_s_data), .S_VALID(a_s_valid), .S_READY(a_s_ready),
    .M_DATA(a_m_data), .M_VALID(a_m_valid), .M_READY(a_m_ready),
    .COUNT(a_count), .AFULL(a_afull), .AEMPTY(a_aempty)
  );

  srl_fifo #(.WIDTH(W), .DEPTH(DB), .IS_CLK_INVERTED(1'b1)) u_dut_b (
    .CLK(clk), .RST_N(rst_n), .CE(b_ce), .CLR(b_clr),
    .S_DATA(b_s_data), .S_VALID(b_s_valid), .S_READY(b_s_ready),
    .M_DATA(b_m_data), .M_VALID(b_m_valid), .M_READY(b_m_ready),
    .COUNT(b_count), .AFULL(b_afull), .AEMPTY(b_aempty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_a(input string tag);
    int n;
    n = q_a.size();
    check({tag, "/a_count"},   32'(a_count),   32'(n));
    check({tag, "/a_s_ready"}, 32'(a_s_ready), 32'(a_ce && rdy_a && n < DA));
    check({tag, "/a_m_valid"}, 32'(a_m_valid), 32'(a_ce && n > 0));
    check({tag, "/a_afull"},   32'(a_afull),   32'(n >= AF_A));
    check({tag, "/a_aempty"},  32'(a_aempty),  32'(n <= AE_A));
    if (n > 0)
      check({tag, "/a_m_data"}, 32'(a_m_data), 32'(q_a[0]));
  endtask

  task automatic check_b(input string tag);
    int n;
    n = q_b.size();
    check({tag, "/b_count"},   32'(b_count),   32'(n));
    check({tag, "/b_s_ready"}, 32'(b_s_ready), 32'(b_ce && rdy_b && n < DB));
    check({tag, "/b_m_valid"}, 32'(b_m_valid), 32'(b_ce && n > 0));
    check({tag, "/b_afull"},   32'(b_afull),   32'(n >= AF_B));
    check({tag, "/b_aempty"},  32'(b_aempty),  32'(n <= AE_B));
    if (n > 0)
      check({tag, "/b_m_data"}, 32'(b_m_data), 32'(q_b[0]));
  endtask

  // Called at a falling edge; drives, lets the rising edge act, checks at the next falling edge.
  task automatic cycle_a(input string tag, input logic ce, input logic clr, input logic sv,
                         input logic [W-1:0] sd, input logic mr);
    bit push, pop;
    a_ce = ce; a_clr = clr; a_s_valid = sv; a_s_data = sd; a_m_ready = mr;
    push = ce && sv && rdy_a && (q_a.size() < DA);
    pop  = ce && mr && (q_a.size() > 0);
    @(posedge clk);
    if (ce) begin
      rdy_a = 1'b1;
      if (clr) q_a.delete();
      else begin
        if (pop)  void'(q_a.pop_front());
        if (push) q_a.push_back(sd);
      end
    end
    @(negedge clk);
    check_a(tag);
  endtask

  // Called just after a rising edge; the falling edge is the active one.
  task automatic cycle_b(input string tag, input logic ce, input logic clr, input logic sv,
                         input logic [W-1:0] sd, input logic mr);
    bit push, pop;
    b_ce = ce; b_clr = clr; b_s_valid = sv; b_s_data = sd; b_m_ready = mr;
    push = ce && sv && rdy_b && (q_b.size() < DB);
    pop  = ce && mr && (q_b.size() > 0);
    @(negedge clk);
    if (ce) begin
      rdy_b = 1'b1;
      if (clr) q_b.delete();
      else begin
        if (pop)  void'(q_b.pop_front());
        if (push) q_b.push_back(sd);
      end
    end
    @(posedge clk);
    #1;
    check_b(tag);
  endtask

  initial begin
    logic ce, clr, sv, mr;
    bit fill_mode;
    logic [W-1:0] nxt, out_exp;

    rst_n = 1'b0;
    a_ce = 1'b1; a_clr = 1'b0; a_s_valid = 1'b0; a_s_data = '0; a_m_ready = 1'b0;
    b_ce = 1'b1; b_clr = 1'b0; b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0;
    rdy_a = 1'b0;
    rdy_b = 1'b0;

    repeat (3) @(negedge clk);
    check("rst/a_s_ready", 32'(a_s_ready), 32'd0);
    check("rst/a_m_valid", 32'(a_m_valid), 32'd0);
    check("rst/a_count",   32'(a_count),   32'd0);
    check("rst/a_aempty",  32'(a_aempty),  32'd1);
    check("rst/a_afull",   32'(a_afull),   32'd0);
    check("rst/b_s_ready", 32'(b_s_ready), 32'd0);
    check("rst/b_count",   32'(b_count),   32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cycle_a("release", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("release/a_s_ready_hi", 32'(a_s_ready), 32'd1);
    #1;
    check("release/b_s_ready_hi", 32'(b_s_ready), 32'd1);
    rdy_b = 1'b1;
    @(negedge clk);

    for (int i = 0; i < DA; i++) begin
      cycle_a("fill", 1'b1, 1'b0, 1'b1, W'(i), 1'b0);
      if (i == 28) check("fill/afull_29", 32'(a_afull), 32'd0);
      if (i == 29) check("fill/afull_30", 32'(a_afull), 32'd1);
    end
    check("fill/count_full", 32'(a_count),   32'd32);
    check("fill/s_ready_lo", 32'(a_s_ready), 32'd0);
    cycle_a("push_full", 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);

    for (int i = 0; i < DA; i++) begin
      check("drain/order", 32'(a_m_data), 32'(i));
      if (i == 31) check("drain/aempty_1", 32'(a_aempty), 32'd1);
      if (i == 30) check("drain/aempty_2", 32'(a_aempty), 32'd0);
      cycle_a("drain", 1'b1, 1'b0, 1'b0, '0, 1'b1);
    end
    check("drain/m_valid_lo", 32'(a_m_valid), 32'd0);

    nxt = '0;
    for (int i = 0; i < 5; i++) begin
      cycle_a("prime5", 1'b1, 1'b0, 1'b1, nxt, 1'b0);
      nxt++;
    end
    out_exp = '0;
    for (int i = 0; i < 100; i++) begin
      check("stream/order", 32'(a_m_data), 32'(out_exp));
      cycle_a("stream", 1'b1, 1'b0, 1'b1, nxt, 1'b1);
      nxt++;
      out_exp++;
    end
    check("stream/count5", 32'(a_count), 32'd5);

    for (int i = 0; i < DA - 5; i++) begin
      cycle_a("refill", 1'b1, 1'b0, 1'b1, nxt, 1'b0);
      nxt++;
    end
    cycle_a("full_pop", 1'b1, 1'b0, 1'b1, 8'hAA, 1'b1);
    check("full_pop/count31",   32'(a_count),   32'd31);
    check("full_pop/s_ready_hi", 32'(a_s_ready), 32'd1);

    cycle_a("clr0", 1'b1, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 12; i++)
      cycle_a("fill12", 1'b1, 1'b0, 1'b1, W'(8'h40 + i), 1'b0);
    cycle_a("clr12", 1'b1, 1'b1, 1'b1, 8'h55, 1'b1);
    check("clr12/count0",    32'(a_count),   32'd0);
    check("clr12/m_valid",   32'(a_m_valid), 32'd0);
    check("clr12/aempty",    32'(a_aempty),  32'd1);
    cycle_a("post_clr", 1'b1, 1'b0, 1'b1, 8'h77, 1'b0);
    check("post_clr/m_data", 32'(a_m_data),  32'h77);
    check("post_clr/count1", 32'(a_count),   32'd1);

    cycle_a("pre_ce", 1'b1, 1'b0, 1'b1, 8'h78, 1'b0);
    cycle_a("pre_ce", 1'b1, 1'b0, 1'b1, 8'h79, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle_a("ce_off", 1'b0, 1'b1, 1'b1, 8'hEE, 1'b1);
    check("ce_off/count3",  32'(a_count),  32'd3);
    check("ce_off/m_data",  32'(a_m_data), 32'h77);
    check("ce_off/aempty",  32'(a_aempty), 32'd0);

    for (int k = 0; k < 2000; k++) begin
      fill_mode = ((k / 250) % 2) == 0;
      ce  = ($urandom_range(0, 15) != 0);
      clr = ($urandom_range(0, 99) == 0);
      sv  = fill_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      mr  = fill_mode ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle_a("rand_a", ce, clr, sv, W'($urandom), mr);
    end

    a_ce = 1'b0; a_s_valid = 1'b0; a_m_ready = 1'b0; a_clr = 1'b0;
    @(posedge clk);
    #1;
    check_b("b_idle");
    for (int i = 0; i < DB; i++)
      cycle_b("b_fill", 1'b1, 1'b0, 1'b1, W'(8'hB0 + i), 1'b0);
    check("b_fill/count3",     32'(b_count),   32'd3);
    check("b_fill/s_ready_lo", 32'(b_s_ready), 32'd0);
    check("b_fill/m_data",     32'(b_m_data),  32'hB0);
    cycle_b("b_push_full", 1'b1, 1'b0, 1'b1, 8'hCC, 1'b0);

    for (int k = 0; k < 10000; k++) begin
      fill_mode = ((k / 20) % 2) == 0;
      ce  = ($urandom_range(0, 15) != 0);
      clr = ($urandom_range(0, 199) == 0);
      sv  = fill_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      mr  = fill_mode ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle_b("rand_b", ce, clr, sv, W'($urandom), mr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
